buma_cmp: RTL and testbench
===========================

# buma_cmp

Registered two's-complement magnitude comparator. Each accepted sample compares operands `A` and `B` and drives `O` high when `A` is strictly less than `B`. An unsigned mode is selectable per sample. The block is a leaf datapath element: it takes operand pairs from upstream logic and presents a one-cycle-latency compare flag to downstream control.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1  qualifies `A`, `B` and `mode` for the current cycle.
- `mode`  input  1  0 = signed two's-complement compare; 1 = unsigned compare.
- `A`  input  WIDTH  first operand.
- `B`  input  WIDTH  second operand.
- `O`  output  1  registered result, 1 when A < B under the sampled mode.
- `out_valid`  output  1  high for one cycle per accepted sample.
- `EQ`  output  1  registered A == B flag; present only with `BUMA_EQ_FLAG_EN`.

## Operation
- Signed mode (`mode`=0):
  - Operands are two's complement; MSB is the sign bit.
  - If the sign bits differ, the operand with MSB=1 is smaller.
  - If the sign bits are equal, compare the lower WIDTH-1 bits as unsigned.
- Unsigned mode (`mode`=1): plain unsigned compare of all WIDTH bits.
- O = 1 only for strict less-than; A == B gives O = 0 in both modes.
- Boundaries:
  - Most-negative vs most-positive (4'b1000 vs 4'b0111) in signed mode: O = 1.
  - The same pair in unsigned mode: O = 0.
- No overflow is possible: the compare is not implemented as a truncated WIDTH-bit subtraction.
- Mode is sampled together with the operands, per sample; there is no persistent mode state.
- No internal state beyond the output registers; no FSM.

## Timing
- Latency is 1 cycle: a sample accepted at edge N (in_valid=1) drives `O`/`EQ` and `out_valid`=1 after edge N.
- `in_valid`=0 at an edge:
  - `out_valid` goes to 0.
  - `O`/`EQ` hold their previous values.
- Back-to-back samples on every cycle are supported; throughput is one per clock. There is no backpressure.
- Reset values: `O`=0, `EQ`=0, `out_valid`=0.
- Reset takes priority over `in_valid` at the same edge. A sample presented on a reset edge is discarded.
- Reset deasserted: the first sample is accepted on the next edge with `in_valid`=1.
- Outputs never change between edges; there is no combinational path from inputs to outputs.

## Configuration
- `BUMA_EQ_FLAG_EN` defined:
  - Port `EQ` exists.
  - EQ is registered alongside `O` with the same enable and reset rules.
  - EQ = 1 when A == B, bitwise, independent of mode.
- `BUMA_EQ_FLAG_EN` undefined:
  - Port `EQ` and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset asserted for 2 cycles with in_valid=1, A=4'b0001, B=4'b0101 -> O=0, out_valid=0 (EQ=0) throughout reset.
- After reset: in_valid=1, mode=0, A=4'b0001, B=4'b0101 -> next cycle O=1, out_valid=1. Then in_valid=0 -> out_valid=0, O holds 1.
- A=4'b1111, B=4'b0001: with mode=0 -> O=1; with mode=1 -> O=0. Issue back-to-back -> results appear on consecutive cycles.
- A=4'b1000, B=4'b0111: mode=0 -> O=1; mode=1 -> O=0. Then A=B=4'b1010 -> O=0, EQ=1 (macro on).
- Reset mid-stream after an O=1 result -> O=0 and out_valid=0 on the following edge. The sample presented during reset is produced nowhere.
- Exhaustive sweep of all 256 A/B pairs in both modes against a signed/unsigned reference model -> zero mismatches.

Source files
------------

// File: rtl/buma_cmp.sv
// buma_cmp: registered signed/unsigned A<B comparator, 1-cycle latency; EQ flag under BUMA_EQ_FLAG_EN
module buma_cmp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef BUMA_EQ_FLAG_EN
    output logic             EQ,
`endif
    output logic             O,
    output logic             out_valid
);
    logic sign_diff;
    logic low_lt;
    logic lt;
    assign sign_diff = A[WIDTH-1] ^ B[WIDTH-1];
    assign low_lt = A[WIDTH-2:0] < B[WIDTH-2:0];
    // differing MSBs: signed picks the negative side (A MSB set), unsigned picks the smaller MSB (B MSB set)
    always_comb lt = sign_diff ? (mode ? B[WIDTH-1] : A[WIDTH-1]) : low_lt;
    // output registers: reset clears, accepted sample loads, idle cycle holds flags
    always_ff @(posedge clk) begin
        if (reset) begin
            O <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) O <= lt;
        end
    end
`ifdef BUMA_EQ_FLAG_EN
    // equality flag shares the enable and reset of O, independent of mode
    always_ff @(posedge clk) begin
        if (reset) EQ <= 1'b0;
        else if (in_valid) EQ <= (A == B);
    end
`endif
endmodule

// File: tb/tb_buma_cmp.sv
// tb_buma_cmp: scoreboard bench for buma_cmp; EQ checked when BUMA_EQ_FLAG_EN is defined
module tb_buma_cmp;
    typedef struct packed {
        logic v;
        logic o;
        logic eq;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       O;
    logic       out_valid;
`ifdef BUMA_EQ_FLAG_EN
    logic       EQ;
`endif
    exp_t       q[$];
    exp_t       e;
    logic       m_o = 1'b0;
    logic       m_eq = 1'b0;
    int         pass = 0;
    int         total = 0;
    buma_cmp #(.WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .mode(mode),
        .A(A),
        .B(B),
`ifdef BUMA_EQ_FLAG_EN
        .EQ(EQ),
`endif
        .O(O),
        .out_valid(out_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
    endtask
    // drive one cycle of inputs, then push the reference model's expected outputs for that edge
    task automatic step(input logic r, input logic v, input logic m, input logic [3:0] a, input logic [3:0] b);
        exp_t x;
        reset = r;
        in_valid = v;
        mode = m;
        A = a;
        B = b;
        @(posedge clk);
        if (r) begin
            m_o = 1'b0;
            m_eq = 1'b0;
        end else if (v) begin
            m_o = m ? (a < b) : ($signed(a) < $signed(b));
            m_eq = (a == b);
        end
        x.v = !r && v;
        x.o = m_o;
        x.eq = m_eq;
        q.push_back(x);
        #1;
    endtask
    // monitor: compare DUT against the oldest expectation, away from the active edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", out_valid, e.v);
            chk("O", O, e.o);
`ifdef BUMA_EQ_FLAG_EN
            chk("EQ", EQ, e.eq);
`endif
        end
    end
    initial begin
        step(1, 1, 0, 4'b0001, 4'b0101);
        step(1, 1, 0, 4'b0001, 4'b0101);
        step(0, 1, 0, 4'b0001, 4'b0101);
        step(0, 0, 0, 4'b0000, 4'b0000);
        step(0, 1, 0, 4'b1111, 4'b0001);
        step(0, 1, 1, 4'b1111, 4'b0001);
        step(0, 1, 0, 4'b1000, 4'b0111);
        step(0, 1, 1, 4'b1000, 4'b0111);
        step(0, 1, 0, 4'b1010, 4'b1010);
        step(0, 1, 1, 4'b1010, 4'b1010);
        step(0, 0, 1, 4'b0000, 4'b1111);
        step(0, 1, 0, 4'b1000, 4'b0111);
        step(1, 1, 0, 4'b1000, 4'b0111);
        step(0, 0, 0, 4'b1000, 4'b0111);
        step(0, 1, 1, 4'b0111, 4'b1000);
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    step(0, 1, m[0], 4'(a), 4'(b));
        step(0, 0, 0, 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        total++;
        if (q.size() == 0) pass++;
        else $display("FAIL drain: got=%0d pending expected=0", q.size());
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
